// File: rtl/app_state_ctrl.sv
// Screen selector for a small handheld: lock screen, menu and apps, with a
// mic-level shortcut into one app and an idle timer that falls back to the lock screen.
module app_state_ctrl #(
  parameter int NUM_APPS      = 5,
  parameter int STATE_W       = 3,
  parameter int PASS_IDX      = 5,
  parameter int MIC_APP       = 4,
  parameter int MIC_HOLD      = 25,
  parameter int IDLE_TICKS    = 3000,
  parameter int LOCK_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_sel,
  input  logic               btn_back,
  input  logic [STATE_W-1:0] menu_sel,
  input  logic               pw_flag,
  input  logic [3:0]         mic_level,
  input  logic [3:0]         mic_thresh,
  input  logic               lock_en,
  output logic [STATE_W-1:0] state,
  output logic [NUM_APPS:0]  app_en,
  output logic               locked,
  output logic               switch_pulse
);

  localparam int MIC_W  = $clog2(MIC_HOLD + 1);
  localparam int IDLE_W = $clog2(IDLE_TICKS + 1);

  localparam logic [STATE_W-1:0] MENU_S  = '0;
  localparam logic [STATE_W-1:0] LOCK_S  = STATE_W'(PASS_IDX);
  localparam logic [STATE_W-1:0] LAST_S  = STATE_W'(NUM_APPS);
  localparam logic [STATE_W-1:0] MICA_S  = STATE_W'(MIC_APP);
  localparam logic [STATE_W-1:0] RESET_S = (LOCK_ON_RESET != 0) ? LOCK_S : MENU_S;

  localparam logic [MIC_W-1:0]  MIC_MAX  = MIC_W'(MIC_HOLD);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TICKS);

  function automatic logic [NUM_APPS:0] onehot(input logic [STATE_W-1:0] s);
    logic [NUM_APPS:0] v;
    v = '0;
    for (int i = 0; i <= NUM_APPS; i++) begin
      v[i] = (s == STATE_W'(i));
    end
    return v;
  endfunction

  logic [STATE_W-1:0] state_q, state_d;
  logic [MIC_W-1:0]   mic_cnt_q, mic_cnt_d, mic_inc_s;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d, idle_inc_s;
  logic [NUM_APPS:0]  app_en_q, app_en_d;
  logic               locked_q, locked_d;
  logic               switch_q, switch_d;
  logic               in_lock_s, in_menu_s, in_app_s, legal_s;
  logic               sel_ok_s, idle_clr_s, changed_s;

  // State, counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_S;
      mic_cnt_q  <= '0;
      idle_cnt_q <= '0;
      app_en_q   <= onehot(RESET_S);
      locked_q   <= (RESET_S == LOCK_S);
      switch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mic_cnt_q  <= mic_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      app_en_q   <= app_en_d;
      locked_q   <= locked_d;
      switch_q   <= switch_d;
    end
  end

  // Next-state and counter logic; transitions listed in priority order
  always_comb begin
    legal_s   = (state_q <= LAST_S);
    in_lock_s = (state_q == LOCK_S);
    in_menu_s = (state_q == MENU_S);
    in_app_s  = legal_s && !in_lock_s && !in_menu_s;
    sel_ok_s  = (menu_sel != MENU_S) && (menu_sel <= LAST_S);

    if (mic_level >= mic_thresh) begin
      mic_inc_s = (mic_cnt_q == MIC_MAX) ? MIC_MAX : mic_cnt_q + MIC_W'(1);
    end else begin
      mic_inc_s = '0;
    end

    // Idle time only accumulates on user-facing screens with auto-lock armed
    idle_clr_s = btn_sel || btn_back || !lock_en || !(in_menu_s || in_app_s);
    if (idle_clr_s) begin
      idle_inc_s = '0;
    end else begin
      idle_inc_s = (idle_cnt_q == IDLE_MAX) ? IDLE_MAX : idle_cnt_q + IDLE_W'(1);
    end

    state_d = state_q;
    if (!legal_s) begin
      state_d = MENU_S;
    end else if (in_lock_s) begin
      if (pw_flag) begin
        state_d = MENU_S;
      end else begin
        state_d = state_q;
      end
    end else if (in_menu_s) begin
      if (btn_sel && sel_ok_s) begin
        state_d = menu_sel;
      end else if ((MIC_APP != 0) && (mic_inc_s == MIC_MAX)) begin
        state_d = MICA_S;
      end else if (lock_en && (idle_inc_s == IDLE_MAX)) begin
        state_d = LOCK_S;
      end else begin
        state_d = state_q;
      end
    end else begin
      if (btn_back) begin
        state_d = MENU_S;
      end else if (lock_en && (idle_inc_s == IDLE_MAX)) begin
        state_d = LOCK_S;
      end else begin
        state_d = state_q;
      end
    end

    changed_s  = (state_d != state_q);
    mic_cnt_d  = changed_s ? '0 : mic_inc_s;
    idle_cnt_d = changed_s ? '0 : idle_inc_s;
  end

  // Output decode from the upcoming state so outputs move with the state register
  always_comb begin
    app_en_d = onehot(state_d);
    locked_d = (state_d == LOCK_S);
    switch_d = (state_d != state_q);
  end

  assign state        = state_q;
  assign app_en       = app_en_q;
  assign locked       = locked_q;
  assign switch_pulse = switch_q;

endmodule
